// File: rtl/smod_pipe.sv
// smod_pipe: WIDTH-bit ACT-style 4:1 select cell feeding a DEPTH-stage
// register pipeline with valid tagging, clock-enable stall and CLR flush.
//
// Ports:
//   clk            rising-edge clock
//   CLR            synchronous active-high clear of every stage
//   en             pipeline advance; 0 holds every stage
//   in_valid       qualifies this cycle's data/select inputs
//   d0..d3 [W]     mux data inputs
//   a0,a1  [SW]    low-select terms (s_lo = a0 & a1)
//   b0,b1  [SW]    high-select terms (s_hi = b0 | b1)
//   q      [W]     last pipeline stage
//   q_valid        q holds valid data
//   q_par          even parity of q (only when SMOD_PARITY_EN is defined)
//
// Optional feature macro: SMOD_PARITY_EN adds the registered q_par output.
// SW = WIDTH when SEL_PER_BIT=1 (one select set per bit), else 1 (shared).

module smod_pipe #(
  parameter int WIDTH       = 8,
  parameter int DEPTH       = 1,
  parameter int SEL_PER_BIT = 0,
  localparam int SW = (SEL_PER_BIT != 0) ? WIDTH : 1
) (
  input  logic             clk,
  input  logic             CLR,
  input  logic             en,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] d0,
  input  logic [WIDTH-1:0] d1,
  input  logic [WIDTH-1:0] d2,
  input  logic [WIDTH-1:0] d3,
  input  logic [SW-1:0]    a0,
  input  logic [SW-1:0]    a1,
  input  logic [SW-1:0]    b0,
  input  logic [SW-1:0]    b1,
  output logic [WIDTH-1:0] q,
  output logic             q_valid
`ifdef SMOD_PARITY_EN
  ,
  output logic             q_par
`endif
);

  logic [WIDTH-1:0] mux;
  logic [WIDTH-1:0] data [DEPTH];
  logic [DEPTH-1:0] v;

  // Select cell: bit i uses select set i, or set 0 when shared.
  for (genvar i = 0; i < WIDTH; i++) begin : g_mux
    localparam int S = (SEL_PER_BIT != 0) ? i : 0;
    logic lo;
    logic hi;
    assign lo = a0[S] & a1[S];
    assign hi = b0[S] | b1[S];
    always_comb begin
      mux[i] = d0[i];
      unique case ({hi, lo})
        2'b00:   mux[i] = d0[i];
        2'b01:   mux[i] = d1[i];
        2'b10:   mux[i] = d2[i];
        2'b11:   mux[i] = d3[i];
        default: mux[i] = d0[i];
      endcase
    end
  end

  // Data is captured even when in_valid=0; only v marks it.
  always_ff @(posedge clk) begin
    if (CLR) begin
      for (int k = 0; k < DEPTH; k++) begin
        data[k] <= '0;
      end
      v <= '0;
    end else if (en) begin
      data[0] <= mux;
      v[0]    <= in_valid;
      for (int k = 1; k < DEPTH; k++) begin
        data[k] <= data[k-1];
        v[k]    <= v[k-1];
      end
    end
  end

  assign q       = data[DEPTH-1];
  assign q_valid = v[DEPTH-1];

`ifdef SMOD_PARITY_EN
  // Parity is computed from what enters the last stage so it is a
  // register output aligned with q, never an XOR hanging off q.
  logic [WIDTH-1:0] last_nxt;
  logic             par_r;

  if (DEPTH == 1) begin : g_par_d1
    assign last_nxt = mux;
  end else begin : g_par_dn
    assign last_nxt = data[DEPTH-2];
  end

  always_ff @(posedge clk) begin
    if (CLR) begin
      par_r <= 1'b0;
    end else if (en) begin
      par_r <= ^last_nxt;
    end
  end

  assign q_par = par_r;
`endif

endmodule

// File: tb/tb_smod_pipe.sv
// tb_smod_pipe: scoreboard bench for smod_pipe.
// Three instances: shared-select D1, per-bit-select D1, shared-select D3.

module tb_smod_pipe;

`ifdef SMOD_PARITY_EN
  localparam bit PAR = 1'b1;
`else
  localparam bit PAR = 1'b0;
`endif

  typedef struct {
    logic [7:0] d;
    logic       p;
    int         due;
  } exp_t;

  logic clk = 1'b0;
  logic clr = 1'b1;
  logic en  = 1'b1;

  logic       iv1, iv2, iv3;
  logic [7:0] d01, d11, d21, d31;
  logic [7:0] d02, d12, d22, d32;
  logic [7:0] d03, d13, d23, d33;
  logic       a01, a11, b01, b11;
  logic [7:0] a02, a12, b02, b12;
  logic       a03, a13, b03, b13;
  logic [7:0] q1, q2, q3;
  logic       qv1, qv2, qv3;
  logic       qp1, qp2, qp3;

  exp_t sb [3][$];
  int   n_chk = 0;
  int   n_fail = 0;
  int   ecnt = 0;
  bit   adv = 1'b0;
  bit   clr_s = 1'b1;
  logic [7:0] prevq [3];
  logic       prevv [3];

  always #5 clk = ~clk;

  smod_pipe #(.WIDTH(8), .DEPTH(1), .SEL_PER_BIT(0)) u1 (
    .clk(clk), .CLR(clr), .en(en), .in_valid(iv1),
    .d0(d01), .d1(d11), .d2(d21), .d3(d31),
    .a0(a01), .a1(a11), .b0(b01), .b1(b11),
    .q(q1), .q_valid(qv1)
`ifdef SMOD_PARITY_EN
    , .q_par(qp1)
`endif
  );

  smod_pipe #(.WIDTH(8), .DEPTH(1), .SEL_PER_BIT(1)) u2 (
    .clk(clk), .CLR(clr), .en(en), .in_valid(iv2),
    .d0(d02), .d1(d12), .d2(d22), .d3(d32),
    .a0(a02), .a1(a12), .b0(b02), .b1(b12),
    .q(q2), .q_valid(qv2)
`ifdef SMOD_PARITY_EN
    , .q_par(qp2)
`endif
  );

  smod_pipe #(.WIDTH(8), .DEPTH(3), .SEL_PER_BIT(0)) u3 (
    .clk(clk), .CLR(clr), .en(en), .in_valid(iv3),
    .d0(d03), .d1(d13), .d2(d23), .d3(d33),
    .a0(a03), .a1(a13), .b0(b03), .b1(b13),
    .q(q3), .q_valid(qv3)
`ifdef SMOD_PARITY_EN
    , .q_par(qp3)
`endif
  );

`ifndef SMOD_PARITY_EN
  assign qp1 = 1'b0;
  assign qp2 = 1'b0;
  assign qp3 = 1'b0;
`endif

  // Advance-edge bookkeeping: ecnt counts en=1, CLR=0 edges.
  always @(posedge clk) begin
    adv   = en && !clr;
    clr_s = clr;
    if (adv) ecnt++;
  end

  task automatic mon(input int k, input string nm,
                     input logic [7:0] q, input logic qv,
                     input logic qp);
    exp_t e;
    if (!clr_s) begin
      if (!adv) begin
        n_chk++;
        if (q !== prevq[k] || qv !== prevv[k]) begin
          n_fail++;
          $display("FAIL %s_hold: got q=%h v=%b need q=%h v=%b",
                   nm, q, qv, prevq[k], prevv[k]);
        end
      end else if (qv === 1'b1) begin
        n_chk++;
        if (sb[k].size() == 0) begin
          n_fail++;
          $display("FAIL %s_extra: got q=%h need no valid word",
                   nm, q);
        end else begin
          e = sb[k].pop_front();
          if (q !== e.d || ecnt != e.due ||
              (PAR && qp !== e.p)) begin
            n_fail++;
            $display("FAIL %s_word: got q=%h p=%b edge=%0d need q=%h p=%b edge=%0d",
                     nm, q, qp, ecnt, e.d, e.p, e.due);
          end
        end
      end else if (sb[k].size() > 0 && sb[k][0].due <= ecnt) begin
        n_chk++;
        n_fail++;
        $display("FAIL %s_missing: got no valid need q=%h at edge %0d",
                 nm, sb[k][0].d, sb[k][0].due);
        void'(sb[k].pop_front());
      end
    end
    prevq[k] = q;
    prevv[k] = qv;
  endtask

  always @(negedge clk) begin
    mon(0, "u1", q1, qv1, qp1);
    mon(1, "u2", q2, qv2, qp2);
    mon(2, "u3", q3, qv3, qp3);
  end

  task automatic push(input int k, input logic [7:0] d, input int dep);
    exp_t e;
    e.d = d;
    e.p = ^d;
    e.due = ecnt + dep;
    if (en && !clr) sb[k].push_back(e);
  endtask

  task automatic chk_rst(input string nm, input logic [7:0] q,
                         input logic qv, input logic qp);
    n_chk++;
    if (q !== 8'h00 || qv !== 1'b0 || (PAR && qp !== 1'b0)) begin
      n_fail++;
      $display("FAIL %s_reset: got q=%h v=%b p=%b need 00 0 0",
               nm, q, qv, qp);
    end
  endtask

  task automatic w3(input logic [7:0] d);
    @(negedge clk);
    iv3 = 1'b1;
    d03 = d;
    push(2, d, 3);
  endtask

  logic [7:0] dv [4];
  logic [3:0] c;

  initial begin
    dv[0] = 8'h11; dv[1] = 8'h22; dv[2] = 8'h44; dv[3] = 8'h88;
    iv1 = 1'b1; iv2 = 1'b1; iv3 = 1'b1;
    d01 = 8'($urandom); d11 = 8'($urandom);
    d21 = 8'($urandom); d31 = 8'($urandom);
    d02 = 8'($urandom); d12 = 8'($urandom);
    d22 = 8'($urandom); d32 = 8'($urandom);
    d03 = 8'($urandom); d13 = 8'($urandom);
    d23 = 8'($urandom); d33 = 8'($urandom);
    {a01, a11, b01, b11} = 4'($urandom);
    {a03, a13, b03, b13} = 4'($urandom);
    a02 = 8'($urandom); a12 = 8'($urandom);
    b02 = 8'($urandom); b12 = 8'($urandom);

    // Reset held for two edges with live inputs.
    repeat (2) begin
      @(negedge clk);
      chk_rst("u1", q1, qv1, qp1);
      chk_rst("u2", q2, qv2, qp2);
      chk_rst("u3", q3, qv3, qp3);
    end
    clr = 1'b0;
    iv1 = 1'b0; iv2 = 1'b0; iv3 = 1'b0;

    // Shared select sweep on u1.
    d01 = 8'h11; d11 = 8'h22; d21 = 8'h44; d31 = 8'h88;
    for (int i = 0; i < 16; i++) begin
      c = 4'(i);
      iv1 = 1'b1;
      {b01, b11, a01, a11} = c;
      push(0, dv[{c[3] | c[2], c[1] & c[0]}], 1);
      @(negedge clk);
    end

    // Parity words on u1 (select code 0 -> d0).
    {b01, b11, a01, a11} = 4'b0000;
    d01 = 8'h07;
    push(0, 8'h07, 1);
    @(negedge clk);
    d01 = 8'h03;
    push(0, 8'h03, 1);
    @(negedge clk);
    iv1 = 1'b0;

    // Per-bit select on u2.
    iv2 = 1'b1;
    a02 = 8'h0F; a12 = 8'h0F; b02 = 8'h00; b12 = 8'h00;
    d02 = 8'h00; d12 = 8'hFF; d22 = 8'h00; d32 = 8'h00;
    push(1, 8'h0F, 1);
    @(negedge clk);
    a02 = 8'hAA; a12 = 8'hAA; b02 = 8'hCC; b12 = 8'h00;
    d02 = 8'h00; d12 = 8'h0F; d22 = 8'hF0; d32 = 8'hFF;
    push(1, 8'hCA, 1);
    @(negedge clk);
    iv2 = 1'b0;

    // Latency and stall on u3 (select code 0 -> d0).
    {b03, b13, a03, a13} = 4'b0000;
    iv3 = 1'b1;
    d03 = 8'h01;
    push(2, 8'h01, 3);
    w3(8'h02);
    @(negedge clk);
    en = 1'b0;
    d03 = 8'hEE;
    repeat (2) @(negedge clk);
    en = 1'b1;
    d03 = 8'h03;
    push(2, 8'h03, 3);
    @(negedge clk);
    iv3 = 1'b0;
    repeat (5) @(negedge clk);

    // Flush: two words in flight, then CLR, then A5.
    w3(8'h10);
    w3(8'h20);
    @(negedge clk);
    iv3 = 1'b0;
    clr = 1'b1;
    sb[2].delete();
    @(negedge clk);
    clr = 1'b0;
    iv3 = 1'b1;
    d03 = 8'hA5;
    push(2, 8'hA5, 3);
    @(negedge clk);
    iv3 = 1'b0;

    repeat (10) @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      n_chk++;
      if (sb[k].size() != 0) begin
        n_fail++;
        $display("FAIL drain_%0d: got %0d pending need 0",
                 k, sb[k].size());
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
